// File: rtl/smm_pkg.sv
// smm_pkg: shared types and defaults for the systolic matrix-multiply driver.
//   smm_drv_state_t : driver FSM states
//   SMM_SIZE/SMM_WIDTHX/SMM_WIDTH : default matrix order and word widths
//   idx2rc()        : row-major element index -> {row, col}
package smm_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} smm_drv_state_t;

  localparam int unsigned SMM_SIZE   = 2;
  localparam int unsigned SMM_WIDTHX = 8;
  localparam int unsigned SMM_WIDTH  = 4;
  localparam int unsigned SMM_IDX_W  = (SMM_SIZE > 1) ? $clog2(SMM_SIZE) : 1;

  typedef struct packed {
    logic [SMM_IDX_W-1:0] row;
    logic [SMM_IDX_W-1:0] col;
  } smm_rc_t;

  function automatic smm_rc_t idx2rc(input int unsigned idx, input int unsigned size);
    smm_rc_t rc;
    rc.row = SMM_IDX_W'(idx / size);
    rc.col = SMM_IDX_W'(idx % size);
    return rc;
  endfunction

endpackage

// File: rtl/smm_result_buf.sv
// smm_result_buf: SIZE*SIZE x WIDTH capture register with a row-major read mux.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture prod_i this cycle
//   prod_i        : [SIZE][SIZE][WIDTH] product array from the core
//   sel_i         : row-major element index to read
//   data_o        : selected element
module smm_result_buf
  import smm_pkg::*;
#(
  parameter int unsigned SIZE  = SMM_SIZE,
  parameter int unsigned WIDTH = SMM_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   load_i,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]   prod_i,
  input  logic [$clog2(SIZE*SIZE)-1:0]           sel_i,
  output logic [WIDTH-1:0]                       data_o
);

  // Packed [row][col] flattens so that element (r,c) sits at flat index r*SIZE+c,
  // which makes a plain copy row-major.
  logic [SIZE*SIZE-1:0][WIDTH-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (load_i) begin
      mem_q <= prod_i;
    end
  end

  assign data_o = mem_q[sel_i];

endmodule

// File: rtl/systolic_mm_driver.sv
// systolic_mm_driver: job initiator and result reader for the systolic MM core.
//   Accepts one job (SIZE A words, SIZE B words), streams it to the core one
//   word per cycle, waits for the core's done strobe, captures the SIZE x SIZE
//   product and returns it row-major on a valid/ready stream.
// Ports:
//   clock, nreset               : clock, asynchronous active-low reset
//   job_valid_i/job_ready_o     : job handshake; job_a_i/job_b_i word k at [k*WIDTHx +: WIDTHx]
//   mm_valid_o, mm_a_o, mm_b_o  : operand stream to the core
//   mm_ready_i, mm_prod_i       : core done strobe and product array
//   res_valid_o/res_ready_i     : result handshake
//   res_data_o, res_row_o, res_col_o, res_last_o : result element and position
//   timeout_o                   : sticky watchdog flag (only with SMM_DRV_TIMEOUT_EN)
// Build option: define SMM_DRV_TIMEOUT_EN to add the WAIT watchdog (TO_CYC cycles).
module systolic_mm_driver
  import smm_pkg::*;
#(
  parameter int unsigned SIZE   = SMM_SIZE,
  parameter int unsigned WIDTHx = SMM_WIDTHX,
  parameter int unsigned WIDTH  = SMM_WIDTH
`ifdef SMM_DRV_TIMEOUT_EN
  , parameter int unsigned TO_CYC = 64
`endif
) (
  input  logic                                   clock,
  input  logic                                   nreset,
  input  logic                                   job_valid_i,
  output logic                                   job_ready_o,
  input  logic [SIZE*WIDTHx-1:0]                 job_a_i,
  input  logic [SIZE*WIDTHx-1:0]                 job_b_i,
  output logic                                   mm_valid_o,
  output logic [WIDTHx-1:0]                      mm_a_o,
  output logic [WIDTHx-1:0]                      mm_b_o,
  input  logic                                   mm_ready_i,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]   mm_prod_i,
  output logic                                   res_valid_o,
  input  logic                                   res_ready_i,
  output logic [WIDTH-1:0]                       res_data_o,
  output logic [$clog2(SIZE)-1:0]                res_row_o,
  output logic [$clog2(SIZE)-1:0]                res_col_o,
  output logic                                   res_last_o
`ifdef SMM_DRV_TIMEOUT_EN
  , output logic                                 timeout_o
`endif
);

  localparam int unsigned BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned EW = $clog2(SIZE*SIZE);
  localparam int unsigned RW = $clog2(SIZE);

  smm_drv_state_t                state_q;
  logic [BW-1:0]                 beat_q;
  logic [EW-1:0]                 elem_q;
  // Word 0 goes out straight from the job inputs on the handshake edge, so only
  // words 1..SIZE-1 need latching; word j here is operand word j+1.
  logic [(SIZE-1)*WIDTHx-1:0]    a_q, b_q;
  logic                          mm_valid_q, res_valid_q, job_ready_q;
  logic [WIDTHx-1:0]             mm_a_q, mm_b_q;
  logic [WIDTHx-1:0]             nxt_a, nxt_b;
  logic [WIDTH-1:0]              buf_data;
  logic                          buf_load;
  smm_rc_t                       rc;
  logic                          elem_last;

`ifdef SMM_DRV_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYC + 1);
  logic [CW-1:0]                 wait_cnt_q;
  logic                          timeout_q;
  assign timeout_o = timeout_q;
`endif

  always_comb begin
    nxt_a = a_q[32'(beat_q)*WIDTHx +: WIDTHx];
    nxt_b = b_q[32'(beat_q)*WIDTHx +: WIDTHx];
  end

  assign elem_last = (elem_q == EW'(SIZE*SIZE-1));
  assign buf_load  = (state_q == WAIT) && mm_ready_i;
  assign rc        = idx2rc(32'(elem_q), SIZE);

  smm_result_buf #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_buf (
    .clk_i  (clock),
    .rst_ni (nreset),
    .load_i (buf_load),
    .prod_i (mm_prod_i),
    .sel_i  (elem_q),
    .data_o (buf_data)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      elem_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mm_valid_q  <= 1'b0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      res_valid_q <= 1'b0;
      job_ready_q <= 1'b0;
`ifdef SMM_DRV_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          job_ready_q <= 1'b1;
          if (job_valid_i && job_ready_q) begin
            a_q         <= job_a_i[SIZE*WIDTHx-1:WIDTHx];
            b_q         <= job_b_i[SIZE*WIDTHx-1:WIDTHx];
            mm_valid_q  <= 1'b1;
            mm_a_q      <= job_a_i[WIDTHx-1:0];
            mm_b_q      <= job_b_i[WIDTHx-1:0];
            beat_q      <= '0;
            job_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // beat_q names the word currently on mm_a_o/mm_b_o.
          if (beat_q == BW'(SIZE-1)) begin
            mm_valid_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
`ifdef SMM_DRV_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
            state_q    <= WAIT;
          end else begin
            beat_q <= beat_q + 1'b1;
            mm_a_q <= nxt_a;
            mm_b_q <= nxt_b;
          end
        end
        WAIT: begin
          if (mm_ready_i) begin
            elem_q      <= '0;
            res_valid_q <= 1'b1;
            state_q     <= DRAIN;
          end
`ifdef SMM_DRV_TIMEOUT_EN
          else if (wait_cnt_q == CW'(TO_CYC-1)) begin
            timeout_q   <= 1'b1;
            job_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (res_ready_i) begin
            if (elem_last) begin
              res_valid_q <= 1'b0;
              elem_q      <= '0;
              job_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              elem_q <= elem_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign job_ready_o = job_ready_q;
  assign mm_valid_o  = mm_valid_q;
  assign mm_a_o      = mm_a_q;
  assign mm_b_o      = mm_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_valid_q ? buf_data : '0;
  assign res_row_o   = res_valid_q ? RW'(rc.row) : '0;
  assign res_col_o   = res_valid_q ? RW'(rc.col) : '0;
  assign res_last_o  = res_valid_q && elem_last;

endmodule
